// File: rtl/pc_gen_if.sv
// Fetch-side handshake bundle for pc_gen: redirect requests in, fetch PC and
// status flags out. The slave modport is the PC generator itself.
interface pc_gen_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic             stall_i;
  logic             flush_i;
  logic [WIDTH-1:0] flush_pc_i;
  logic             branch_i;
  logic [WIDTH-1:0] branch_pc_i;
  logic             call_i;
  logic             ret_i;
  logic [WIDTH-1:0] pc_o;
  logic             pc_valid_o;
  logic             redirect_pending_o;
  logic             ras_empty_o;
  logic             ras_full_o;

  modport master (
    output start_i, stall_i, flush_i, flush_pc_i, branch_i, branch_pc_i,
           call_i, ret_i,
    input  pc_o, pc_valid_o, redirect_pending_o, ras_empty_o, ras_full_o
  );

  modport slave (
    input  start_i, stall_i, flush_i, flush_pc_i, branch_i, branch_pc_i,
           call_i, ret_i,
    output pc_o, pc_valid_o, redirect_pending_o, ras_empty_o, ras_full_o
  );
endinterface

// File: rtl/pc_gen.sv
// Fetch PC generator: sequential stepping, prioritised redirects
// (flush > branch > return), a one-entry pending redirect that survives
// stalls, and a circular return-address stack that overwrites its oldest
// entry when full.
module pc_gen #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_PC  = '0,
  parameter int               STEP      = 4,
  parameter int               RAS_DEPTH = 4
) (
  input logic     clk_i,
  input logic     rst_i,
  pc_gen_if.slave bus
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam logic [PW-1:0]    PTR_ONE = PW'(1);
  localparam logic [CW-1:0]    CNT_ONE = CW'(1);
  localparam logic [CW-1:0]    CNT_MAX = CW'(RAS_DEPTH);
  localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);

  localparam logic [1:0] PRIO_NONE   = 2'd0;
  localparam logic [1:0] PRIO_RET    = 2'd1;
  localparam logic [1:0] PRIO_BRANCH = 2'd2;
  localparam logic [1:0] PRIO_FLUSH  = 2'd3;

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [1:0]       pend_prio_q, pend_prio_d;
  logic [WIDTH-1:0] pend_pc_q, pend_pc_d;
  logic [PW-1:0]    ras_ptr_q, ras_ptr_d;
  logic [CW-1:0]    ras_cnt_q, ras_cnt_d;
  logic             pc_valid_q, pc_valid_d;
  logic             pending_q, pending_d;
  logic             ras_empty_q, ras_empty_d;
  logic             ras_full_q, ras_full_d;
  logic [WIDTH-1:0] ras_mem_q [RAS_DEPTH];

  logic             ras_we;
  logic [PW-1:0]    ras_waddr;
  logic [WIDTH-1:0] step_pc;
  logic [WIDTH-1:0] ras_top;
  logic             ras_act;
  logic             do_push;
  logic             do_pop;
  logic [1:0]       new_prio;
  logic [WIDTH-1:0] new_tgt;

  // Redirect arbitration and RAS push/pop qualification for this cycle
  always_comb begin
    step_pc  = pc_q + STEP_W;
    ras_top  = ras_mem_q[ras_ptr_q - PTR_ONE];
    // Calls and returns only take effect on an unstalled, running cycle;
    // a stalled return therefore never becomes a pending redirect.
    ras_act  = (state_q != IDLE) && bus.start_i && !bus.stall_i;
    do_push  = ras_act && bus.call_i;
    do_pop   = ras_act && bus.ret_i && (ras_cnt_q != '0);
    new_prio = PRIO_NONE;
    new_tgt  = step_pc;
    if (bus.flush_i) begin
      new_prio = PRIO_FLUSH;
      new_tgt  = bus.flush_pc_i;
    end else if (bus.branch_i) begin
      new_prio = PRIO_BRANCH;
      new_tgt  = bus.branch_pc_i;
    end else if (do_pop) begin
      new_prio = PRIO_RET;
      new_tgt  = ras_top;
    end
  end

  // Next state, next PC and pending-redirect bookkeeping
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_prio_d = pend_prio_q;
    pend_pc_d   = pend_pc_q;
    case (state_q)
      IDLE: begin
        if (bus.start_i) state_d = RUN;
      end
      RUN: begin
        if (!bus.start_i) begin
          state_d     = IDLE;
          pend_prio_d = PRIO_NONE;
        end else if (bus.stall_i) begin
          if (new_prio != PRIO_NONE) begin
            state_d     = HOLD;
            pend_prio_d = new_prio;
            pend_pc_d   = new_tgt;
          end
        end else begin
          pc_d = new_tgt;
        end
      end
      HOLD: begin
        if (!bus.start_i) begin
          state_d     = IDLE;
          pend_prio_d = PRIO_NONE;
        end else if (bus.stall_i) begin
          if ((new_prio != PRIO_NONE) && (new_prio >= pend_prio_q)) begin
            pend_prio_d = new_prio;
            pend_pc_d   = new_tgt;
          end
        end else begin
          pc_d        = (new_prio != PRIO_NONE) ? new_tgt : pend_pc_q;
          pend_prio_d = PRIO_NONE;
          state_d     = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Return-address stack pointer/count update; call+ret replaces the top
  always_comb begin
    ras_ptr_d = ras_ptr_q;
    ras_cnt_d = ras_cnt_q;
    ras_we    = 1'b0;
    ras_waddr = ras_ptr_q;
    if (do_push && do_pop) begin
      ras_we    = 1'b1;
      ras_waddr = ras_ptr_q - PTR_ONE;
    end else if (do_push) begin
      ras_we    = 1'b1;
      ras_ptr_d = ras_ptr_q + PTR_ONE;
      ras_cnt_d = (ras_cnt_q == CNT_MAX) ? ras_cnt_q : ras_cnt_q + CNT_ONE;
    end else if (do_pop) begin
      ras_ptr_d = ras_ptr_q - PTR_ONE;
      ras_cnt_d = ras_cnt_q - CNT_ONE;
    end
    pc_valid_d  = (state_d != IDLE);
    pending_d   = (state_d == HOLD);
    ras_empty_d = (ras_cnt_d == '0);
    ras_full_d  = (ras_cnt_d == CNT_MAX);
  end

  // Control state with synchronous active-low reset; pending target is data
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      pend_prio_q <= PRIO_NONE;
      ras_ptr_q   <= '0;
      ras_cnt_q   <= '0;
      pc_valid_q  <= 1'b0;
      pending_q   <= 1'b0;
      ras_empty_q <= 1'b1;
      ras_full_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_prio_q <= pend_prio_d;
      ras_ptr_q   <= ras_ptr_d;
      ras_cnt_q   <= ras_cnt_d;
      pc_valid_q  <= pc_valid_d;
      pending_q   <= pending_d;
      ras_empty_q <= ras_empty_d;
      ras_full_q  <= ras_full_d;
    end
    pend_pc_q <= pend_pc_d;
  end

  // RAS storage is never cleared; only the count marks valid entries
  always_ff @(posedge clk_i) begin
    if (rst_i && ras_we) ras_mem_q[ras_waddr] <= step_pc;
  end

  assign bus.pc_o               = pc_q;
  assign bus.pc_valid_o         = pc_valid_q;
  assign bus.redirect_pending_o = pending_q;
  assign bus.ras_empty_o        = ras_empty_q;
  assign bus.ras_full_o         = ras_full_q;
endmodule

// File: tb/tb_pc_gen.sv
// Testbench for pc_gen: directed scenarios plus randomized traffic, with a
// queue-based reference model feeding a scoreboard monitor.
module tb_pc_gen;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pc_gen_if #(.WIDTH(W)) bus ();

  pc_gen #(.WIDTH(W), .RESET_PC(32'h0), .STEP(4), .RAS_DEPTH(4)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus.slave)
  );

  typedef struct {
    logic [W-1:0] pc;
    logic v;
    logic p;
    logic e;
    logic f;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model: running flag, optional pending redirect, RAS as a queue
  bit           m_run  = 0;
  bit           m_pend = 0;
  int           m_pprio = 0;
  logic [W-1:0] m_ptgt = '0;
  logic [W-1:0] m_pc   = '0;
  logic [W-1:0] m_ras[$];

  task automatic model_step(input bit r, s, st, f, input logic [W-1:0] fp,
                            input bit b, input logic [W-1:0] bp,
                            input bit c, input bit rt);
    logic [W-1:0] old_pc;
    logic [W-1:0] tgt;
    int           nprio;
    bit           ret_ok;
    old_pc = m_pc;
    if (!r) begin
      m_run = 0; m_pend = 0; m_pc = '0; m_ras.delete();
    end else if (!m_run) begin
      if (s) m_run = 1;
    end else if (!s) begin
      m_run = 0; m_pend = 0;
    end else begin
      ret_ok = !st && rt && (m_ras.size() > 0);
      nprio = 0; tgt = '0;
      if (f)           begin nprio = 3; tgt = fp; end
      else if (b)      begin nprio = 2; tgt = bp; end
      else if (ret_ok) begin nprio = 1; tgt = m_ras[$]; end
      if (st) begin
        if (nprio > 0 && (!m_pend || nprio >= m_pprio)) begin
          m_pend = 1; m_pprio = nprio; m_ptgt = tgt;
        end
      end else begin
        if (nprio > 0)   m_pc = tgt;
        else if (m_pend) m_pc = m_ptgt;
        else             m_pc = old_pc + 32'd4;
        m_pend = 0;
        if (c && ret_ok) m_ras[m_ras.size()-1] = old_pc + 32'd4;
        else begin
          if (ret_ok) void'(m_ras.pop_back());
          if (c) begin
            m_ras.push_back(old_pc + 32'd4);
            if (m_ras.size() > 4) void'(m_ras.pop_front());
          end
        end
      end
    end
  endtask

  task automatic drive(input bit r, s, st, f, input logic [W-1:0] fp,
                       input bit b, input logic [W-1:0] bp,
                       input bit c, input bit rt);
    exp_t e;
    @(negedge clk);
    rst = r; bus.start_i = s; bus.stall_i = st;
    bus.flush_i = f; bus.flush_pc_i = fp;
    bus.branch_i = b; bus.branch_pc_i = bp;
    bus.call_i = c; bus.ret_i = rt;
    model_step(r, s, st, f, fp, b, bp, c, rt);
    e.pc = m_pc; e.v = m_run; e.p = m_pend;
    e.e = (m_ras.size() == 0); e.f = (m_ras.size() == 4);
    exp_q.push_back(e);
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, want);
  endtask

  // Scoreboard monitor: one comparison per presented output cycle
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (bus.pc_o === e.pc && bus.pc_valid_o === e.v && bus.redirect_pending_o === e.p &&
            bus.ras_empty_o === e.e && bus.ras_full_o === e.f) n_pass++;
        else $display("FAIL scoreboard @%0t: got pc=%h v=%b p=%b e=%b f=%b expected pc=%h v=%b p=%b e=%b f=%b",
                      $time, bus.pc_o, bus.pc_valid_o, bus.redirect_pending_o, bus.ras_empty_o,
                      bus.ras_full_o, e.pc, e.v, e.p, e.e, e.f);
      end
    end
  end

  initial begin
    logic [W-1:0] rets [4];
    bus.start_i = 0; bus.stall_i = 0; bus.flush_i = 0; bus.flush_pc_i = '0;
    bus.branch_i = 0; bus.branch_pc_i = '0; bus.call_i = 0; bus.ret_i = 0;

    // Reset then free-running sequential fetch
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); settle();
    chk("reset_pc", bus.pc_o, 32'h0);
    chk("reset_valid", {31'b0, bus.pc_valid_o}, 32'h0);
    chk("reset_empty", {31'b0, bus.ras_empty_o}, 32'h1);
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0); settle();
    chk("start_pc", bus.pc_o, 32'h0);
    chk("start_valid", {31'b0, bus.pc_valid_o}, 32'h1);
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0); settle(); chk("seq_pc1", bus.pc_o, 32'h4);
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0); settle(); chk("seq_pc2", bus.pc_o, 32'h8);

    // Stalled branch held pending, then taken
    drive(1, 1, 0, 0, 0, 1, 32'h10, 0, 0); settle(); chk("br_10", bus.pc_o, 32'h10);
    drive(1, 1, 1, 0, 0, 1, 32'h100, 0, 0); settle();
    chk("hold_pc", bus.pc_o, 32'h10);
    chk("hold_pend", {31'b0, bus.redirect_pending_o}, 32'h1);
    drive(1, 1, 1, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 1, 0, 0, 0, 0, 0, 0); settle();
    chk("hold2_pc", bus.pc_o, 32'h10);
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0); settle();
    chk("release_pc", bus.pc_o, 32'h100);
    chk("release_pend", {31'b0, bus.redirect_pending_o}, 32'h0);

    // Pending replacement by higher priority, lower priority dropped
    drive(1, 1, 1, 0, 0, 1, 32'h100, 0, 0);
    drive(1, 1, 1, 1, 32'h200, 0, 0, 0, 0);
    drive(1, 1, 1, 0, 0, 1, 32'h300, 0, 0);
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0); settle();
    chk("flush_wins_pend", bus.pc_o, 32'h200);

    // Same-cycle flush and branch
    drive(1, 1, 0, 1, 32'h80, 1, 32'h90, 0, 0); settle();
    chk("flush_over_branch", bus.pc_o, 32'h80);

    // Reset during HOLD with a non-empty RAS
    drive(1, 1, 0, 0, 0, 0, 0, 1, 0); settle();
    chk("call_nonempty", {31'b0, bus.ras_empty_o}, 32'h0);
    drive(1, 1, 1, 0, 0, 1, 32'h500, 0, 0);
    drive(0, 1, 1, 0, 0, 1, 32'h600, 0, 0); settle();
    chk("rst_hold_pc", bus.pc_o, 32'h0);
    chk("rst_hold_pend", {31'b0, bus.redirect_pending_o}, 32'h0);
    chk("rst_hold_empty", {31'b0, bus.ras_empty_o}, 32'h1);

    // Five calls into a 4-deep RAS, then five returns
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 0, 0, 0, 1, 32'(i + 1) * 32'h10, 1, 0); settle();
      if (i == 2) chk("ras_not_full_3", {31'b0, bus.ras_full_o}, 32'h0);
      if (i == 3) chk("ras_full_4", {31'b0, bus.ras_full_o}, 32'h1);
    end
    rets[0] = 32'h44; rets[1] = 32'h34; rets[2] = 32'h24; rets[3] = 32'h14;
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 0, 0, 0, 0, 0, 0, 1); settle();
      chk($sformatf("ret_%0d", i), bus.pc_o, rets[i]);
    end
    drive(1, 1, 0, 0, 0, 0, 0, 0, 1); settle();
    chk("ret_empty_fall", bus.pc_o, 32'h18);
    chk("ret_empty_flag", {31'b0, bus.ras_empty_o}, 32'h1);

    // Wrap-around near the top of the address space
    drive(1, 1, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0); settle();
    chk("pc_wrap", bus.pc_o, 32'h0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 99) != 0), ($urandom_range(0, 29) != 0),
            ($urandom_range(0, 9) < 3), ($urandom_range(0, 19) == 0), $urandom & 32'hFFFF_FFFC,
            ($urandom_range(0, 6) == 0), $urandom & 32'hFFFF_FFFC,
            ($urandom_range(0, 6) == 0), ($urandom_range(0, 4) == 0));
    end
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    #2;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter WIDTH, default 32: PC and target width in bits.
REQ-002 Parameter RESET_PC, default 0: PC value after reset.
REQ-003 Parameter STEP, default 4: sequential increment in bytes.
REQ-004 Parameter RAS_DEPTH, default 4: return-address-stack entries, power of two, at least 2.
REQ-005 clk_i  input  1  sole clock; all state changes on its rising edge.
REQ-006 rst_i  input  1  reset; synchronous and active-low.
REQ-007 start_i  input  1  run enable; low holds the PC.
REQ-008 stall_i  input  1  pipeline stall; high blocks PC update.
REQ-009 flush_i  input  1  exception/flush redirect request.
REQ-010 flush_pc_i  input  WIDTH  flush target.
REQ-011 branch_i  input  1  taken branch/jump redirect request.
REQ-012 branch_pc_i  input  WIDTH  branch target.
REQ-013 call_i  input  1  current instruction is a call; push pc_o+STEP.
REQ-014 ret_i  input  1  current instruction is a return; redirect to RAS top.
REQ-015 pc_o  output  WIDTH  current fetch PC, registered.
REQ-016 pc_valid_o  output  1  high in RUN/HOLD while start_i is high.
REQ-017 redirect_pending_o  output  1  high in HOLD state.
REQ-018 ras_empty_o / ras_full_o  output  1 each  RAS occupancy flags.

Function
REQ-019 State machine SHALL have states IDLE, RUN, HOLD.
REQ-020 IDLE: pc_o held; IDLE->RUN when start_i=1; this transition does not update pc_o.
REQ-021 In RUN or HOLD, start_i=0 SHALL return to IDLE, hold pc_o and discard the pending redirect.
REQ-022 Redirect priority, highest first: flush_i, branch_i, ret_i (only when RAS is non-empty), sequential pc_o+STEP.
REQ-023 RUN with stall_i=0: pc_o takes the highest-priority target next cycle.
REQ-024 RUN with stall_i=1: pc_o held; any redirect is latched into a pending register together with its priority, and the state goes to HOLD; with no redirect, the state stays RUN.
REQ-025 HOLD with stall_i=1: a new redirect of equal or higher priority overwrites the pending entry; lower priority is dropped.
REQ-026 HOLD with stall_i=0: pc_o takes the pending target, except that a same-cycle new redirect overrides it; then go to RUN.
REQ-027 Arithmetic is modulo 2^WIDTH; the PC wraps from max-STEP+... to low values with no flag.
REQ-028 call_i and ret_i act only when the state is RUN or HOLD, stall_i=0 and start_i=1.
REQ-029 Push writes pc_o+STEP; push when full overwrites the oldest entry and the count stays RAS_DEPTH.
REQ-030 Pop when empty is ignored; no redirect and no count change.
REQ-031 call_i and ret_i in the same cycle: redirect to the old top, then replace the top with pc_o+STEP; the count is unchanged.
REQ-032 ret_i SHALL pop even when it loses priority to flush_i or branch_i.
REQ-033 flush_i SHALL NOT modify RAS contents.
REQ-034 A push or pop requested in a stalled cycle is ignored and not queued.

Reset
REQ-035 rst_i=0 at a clock edge SHALL set state IDLE, pc_o=RESET_PC, pc_valid_o=0, redirect_pending_o=0, RAS count 0, ras_empty_o=1, ras_full_o=0.
REQ-036 Reset asserted mid-HOLD SHALL discard the pending redirect; reset overrides all other inputs.
REQ-037 RAS entry contents are not reset; only the count is.

Verification (WIDTH=32, STEP=4, RAS_DEPTH=4, RESET_PC=0)
REQ-038 Reset, start_i=1, no stall, 3 cycles -> pc_o 0,0,4,8; pc_valid_o=1 from the second cycle.
REQ-039 pc_o=0x10, stall_i=1, branch to 0x100, then 2 stall cycles, then stall_i=0 -> pc_o held at 0x10, redirect_pending_o=1, then pc_o=0x100 and pending cleared.
REQ-040 In HOLD with branch 0x100 pending, flush to 0x200 -> pending replaced; after the stall drops, pc_o=0x200; a later branch 0x300 during the same HOLD is dropped.
REQ-041 5 calls at pc 0x0,0x10,0x20,0x30,0x40 then 5 rets -> ras_full_o=1 after the 4th call; rets go to 0x44,0x34,0x24,0x14, then the 5th ret falls through to sequential and ras_empty_o=1.
REQ-042 Same-cycle flush_i to 0x80 and branch_i to 0x90, stall_i=0 -> pc_o=0x80.
REQ-043 rst_i=0 for one cycle during HOLD -> pc_o=0, IDLE, redirect_pending_o=0, ras_empty_o=1.
